// File: rtl/serial_add_sub_pkg.sv
// Shared state encoding and operation codes for the bit-serial add/sub unit.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor; op selects the carry or borrow function.
module addsub_bit_cell
    import serial_add_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);

    assign s = a ^ b ^ cin;

    always_comb begin
        cout = (a & b) | ((a ^ b) & cin);
        if (op == OP_SUB) begin
            cout = (~a & b) | (~(a ^ b) & cin);
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one operand bit per clock, LSB first, through a single
// reused bit cell, with valid/ready handshakes on operands and result.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned        CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_res_sr;
    logic               r_cy;
    logic               r_op;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_ovf;

    addsub_bit_cell u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_cy),
        .op   (r_op),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_res_next = {w_s, r_res_sr};

    // Operand MSBs must agree for add and differ for sub before a sign flip counts as overflow.
    assign w_ovf = ((r_a_msb ^ r_b_msb) == r_op) && (w_s != r_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_res_sr    <= '0;
            r_cy        <= 1'b0;
            r_op        <= OP_ADD;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_op    <= op;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next[WIDTH-1:1];
                    r_cy     <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result    <= w_res_next;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_ovf;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign carry_out   = r_carry_out;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomised and directed bench for serial_add_sub against an integer-arithmetic model.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_checks;
    int n_errors;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic void model(input logic iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, t, st, m, h;
        m  = 1 << W;
        h  = 1 << (W - 1);
        ua = int'(ia);
        ub = int'(ib);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        if (iop) begin
            t  = ua - ub;
            c  = (ua < ub);
            st = sa - sb;
        end else begin
            t  = ua + ub;
            c  = (t >= m);
            st = sa + sb;
        end
        r = W'(t);
        v = (st >= h) || (st < -h);
    endfunction

    // Accept one operation and wait (bounded) for res_valid; lat = edges after accept.
    task automatic run_op(input logic iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat);
        int n;
        @(negedge clk);
        op = iop; a = ia; b = ib; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        n = 0;
        while (!res_valid && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL release: res_valid=%b start_ready=%b, need 0/1", res_valid, start_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0 || res_valid !== 1'b0
            || start_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset: result=%h co=%b ov=%b rv=%b sr=%b, need 00/0/0/0/1",
                     result, carry_out, overflow, res_valid, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic iop, input logic [W-1:0] ia,
                            input logic [W-1:0] ib);
        logic [W-1:0] er;
        logic         ec, ev;
        int           lat;
        model(iop, ia, ib, er, ec, ev);
        run_op(iop, ia, ib, lat);
        n_checks++;
        if (lat !== W) begin
            n_errors++;
            $display("FAIL %s latency: got %0d edges, need %0d", name, lat, W);
        end
        n_checks++;
        if (result !== er || carry_out !== ec || overflow !== ev) begin
            n_errors++;
            $display("FAIL %s op=%b a=%h b=%h: got r=%h c=%b v=%b, need r=%h c=%b v=%b",
                     name, iop, ia, ib, result, carry_out, overflow, er, ec, ev);
        end
        release_result();
    endtask

    task automatic test_directed();
        check_op("add_35_4a", 1'b0, 8'h35, 8'h4A);
        check_op("add_ff_01", 1'b0, 8'hFF, 8'h01);
        check_op("add_7f_01", 1'b0, 8'h7F, 8'h01);
        check_op("sub_10_20", 1'b1, 8'h10, 8'h20);
        check_op("sub_80_01", 1'b1, 8'h80, 8'h01);
        check_op("sub_eq",    1'b1, 8'h5C, 8'h5C);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            check_op("random", 1'($urandom), W'($urandom), W'($urandom));
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] er;
        logic         ec, ev;
        int           n;
        model(1'b0, 8'hC3, 8'h9A, er, ec, ev);
        @(negedge clk);
        op = 1'b0; a = 8'hC3; b = 8'h9A; start_valid = 1'b1;
        @(posedge clk); #1;
        // Keep offering a different operation throughout RUN and DONE.
        op = 1'b1; a = 8'h11; b = 8'h77;
        n = 0;
        while (!res_valid && n < 4 * W) begin
            n_checks++;
            if (start_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_run_ready: start_ready=%b, need 0", start_ready);
            end
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== W) begin
            n_errors++;
            $display("FAIL bp_latency: got %0d edges, need %0d", n, W);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b1 || start_ready !== 1'b0 || result !== er || carry_out !== ec
                || overflow !== ev) begin
                n_errors++;
                $display("FAIL bp_hold %0d: rv=%b sr=%b r=%h c=%b v=%b, need 1/0 r=%h c=%b v=%b",
                         i, res_valid, start_ready, result, carry_out, overflow, er, ec, ev);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_exit: rv=%b sr=%b, need 0/1", res_valid, start_ready);
        end
        start_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (start_ready !== 1'b1 || result !== er || carry_out !== ec || overflow !== ev) begin
            n_errors++;
            $display("FAIL bp_idle_hold: sr=%b r=%h c=%b v=%b, need 1 r=%h c=%b v=%b",
                     start_ready, result, carry_out, overflow, er, ec, ev);
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        op = 1'b0; a = 8'hAA; b = 8'h55; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0 || res_valid !== 1'b0
            || start_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_reset: r=%h c=%b v=%b rv=%b sr=%b, need 00/0/0/0/1",
                     result, carry_out, overflow, res_valid, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL after_reset_idle: rv=%b sr=%b, need 0/1", res_valid, start_ready);
        end
        check_op("add_aa_55", 1'b0, 8'hAA, 8'h55);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic         ec, ev;
        logic         iop;
        logic [W-1:0] ia, ib;
        int           n;
        res_ready   = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iop = 1'($urandom); ia = W'($urandom); ib = W'($urandom);
            model(iop, ia, ib, er, ec, ev);
            @(negedge clk);
            n_checks++;
            if (start_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_ready %0d: start_ready=%b, need 1", i, start_ready);
            end
            op = iop; a = ia; b = ib;
            @(posedge clk); #1;
            op = 1'($urandom); a = W'($urandom); b = W'($urandom);
            n = 0;
            while (!res_valid && n < 4 * W) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks++;
            if (n !== W || result !== er || carry_out !== ec || overflow !== ev) begin
                n_errors++;
                $display("FAIL b2b %0d: lat=%0d r=%h c=%b v=%b, need lat=%0d r=%h c=%b v=%b",
                         i, n, result, carry_out, overflow, W, er, ec, ev);
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        res_ready   = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        op          = 1'b0;
        a           = '0;
        b           = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_midrun_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
